// File: rtl/clock_mode_ctrl_if.sv
// Front-panel and counter-side signals of the HH:MM:SS mode controller.
// The controller is the slave; the panel/counter side (or a bench) is the master.
interface clock_mode_ctrl_if;
  logic       i_sw0;
  logic       i_sw1;
  logic       i_sw2;
  logic       i_sec_max;
  logic       i_min_max;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic       o_mode;
  logic [1:0] o_position;
  logic [5:0] o_blink_mask;

  modport master (
    output i_sw0, i_sw1, i_sw2, i_sec_max, i_min_max,
    input  o_sec_inc, o_min_inc, o_hour_inc, o_mode, o_position, o_blink_mask
  );

  modport slave (
    input  i_sw0, i_sw1, i_sw2, i_sec_max, i_min_max,
    output o_sec_inc, o_min_inc, o_hour_inc, o_mode, o_position, o_blink_mask
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// CLOCK/SETUP mode controller: button debounce, 1 s timebase, increment
// enables for the time counters and the blink mask for the digit multiplexer.
module clock_mode_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DEB_DIV   = 500000,
  parameter int BLINK_DIV = 12500000
) (
  input logic              clk,
  input logic              rst_n,
  clock_mode_ctrl_if.slave bus
);
  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DEB_DIV   > 1) ? $clog2(DEB_DIV)   : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam int BTN_MODE = 0;
  localparam int BTN_POS  = 1;
  localparam int BTN_INC  = 2;

  typedef enum logic { MODE_CLOCK = 1'b0, MODE_SETUP = 1'b1 } mode_e;
  typedef enum logic [1:0] { POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2 } pos_e;

  function automatic pos_e next_pos(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            deb_strobe;
  logic [2:0][1:0] hist_q, hist_d;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      press_q, press_d;

  mode_e           state_q, state_d;
  pos_e            pos_q, pos_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic            sec_inc_q, sec_inc_d;
  logic            min_inc_q, min_inc_d;
  logic            hour_inc_q, hour_inc_d;

  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_wrap;
  logic            phase_q, phase_d;
  logic [5:0]      mask_q, mask_d;

  // Buttons: synchronizer, then a three-sample window made of the two stored
  // samples plus the one taken on this strobe.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    sync1_d    = {bus.i_sw2, bus.i_sw1, bus.i_sw0};
    sync2_d    = sync1_q;
    deb_strobe = (deb_cnt_q == DW'(DEB_DIV - 1));
    deb_cnt_d  = deb_strobe ? '0 : deb_cnt_q + DW'(1);
    hist_d     = hist_q;
    deb_d      = deb_q;
    press_d    = '0;
    if (deb_strobe) begin
      for (int b = 0; b < 3; b++) begin
        hist_d[b] = {hist_q[b][0], sync2_q[b]};
        if ({hist_q[b], sync2_q[b]} == 3'b000) begin
          deb_d[b]   = 1'b0;
          press_d[b] = deb_q[b];
        end else if ({hist_q[b], sync2_q[b]} == 3'b111) begin
          deb_d[b] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    tick_cnt_d = tick_cnt_q;
    sec_inc_d  = 1'b0;
    min_inc_d  = 1'b0;
    hour_inc_d = 1'b0;
    tick       = (state_q == MODE_CLOCK) && (tick_cnt_q == TW'(TICK_DIV - 1));
    if (state_q == MODE_CLOCK) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        sec_inc_d  = 1'b1;
        min_inc_d  = bus.i_sec_max;
        hour_inc_d = bus.i_sec_max & bus.i_min_max;
      end
      if (press_q[BTN_MODE]) begin
        state_d    = MODE_SETUP;
        pos_d      = POS_SEC;
        tick_cnt_d = '0;
      end
    end else begin
      // Holding the counter at 0 makes the first tick after SETUP a full period away.
      tick_cnt_d = '0;
      if (press_q[BTN_MODE]) begin
        state_d = MODE_CLOCK;
      end else if (press_q[BTN_POS]) begin
        pos_d = next_pos(pos_q);
      end else if (press_q[BTN_INC]) begin
        sec_inc_d  = (pos_q == POS_SEC);
        min_inc_d  = (pos_q == POS_MIN);
        hour_inc_d = (pos_q == POS_HOUR);
      end
    end
  end

  always_comb begin
    blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    phase_d     = phase_q ^ blink_wrap;
    mask_d      = '0;
    if (state_q == MODE_SETUP && phase_q) begin
      case (pos_q)
        POS_SEC:  mask_d = 6'b000011;
        POS_MIN:  mask_d = 6'b001100;
        POS_HOUR: mask_d = 6'b110000;
        default:  mask_d = 6'b000000;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_cnt_q   <= '0;
      hist_q      <= '1;
      deb_q       <= '1;
      press_q     <= '0;
      state_q     <= MODE_CLOCK;
      pos_q       <= POS_SEC;
      tick_cnt_q  <= '0;
      sec_inc_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      mask_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      hist_q      <= hist_d;
      deb_q       <= deb_d;
      press_q     <= press_d;
      state_q     <= state_d;
      pos_q       <= pos_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_inc_q   <= sec_inc_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.o_sec_inc    = sec_inc_q;
  assign bus.o_min_inc    = min_inc_q;
  assign bus.o_hour_inc   = hour_inc_q;
  assign bus.o_mode       = (state_q == MODE_SETUP);
  assign bus.o_position   = pos_q;
  assign bus.o_blink_mask = mask_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus randomized button traffic,
// with a cycle-level monitor that predicts ticks and the blink mask from time alone.
module tb_clock_mode_ctrl;
  localparam int T = 10;
  localparam int D = 4;
  localparam int B = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Monitor state: cycles since reset release, cycle CLOCK was last entered.
  int         cyc          = 0;
  int         e_cyc        = 0;
  int         mode_changes = 0;
  logic       prev_mode    = 1'b0;
  logic [1:0] prev_pos     = 2'd0;
  int         setup_inc[3] = '{0, 0, 0};
  bit         rand_in      = 1'b0;

  // Reference model of mode/position and of SETUP increments per field.
  int m_mode = 0;
  int m_pos  = 0;
  int m_inc[3];

  always #5 clk = ~clk;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(
    .TICK_DIV (T),
    .DEB_DIV  (D),
    .BLINK_DIV(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic mon_clear();
    cyc       = 0;
    e_cyc     = 0;
    prev_mode = 1'b0;
    prev_pos  = 2'd0;
  endtask

  task automatic monitor();
    logic       sm_e;
    logic       mm_e;
    logic [5:0] exp_mask;
    bit         tk;
    forever begin
      @(posedge clk);
      sm_e = bus.i_sec_max;
      mm_e = bus.i_min_max;
      if (!rst_n) begin
        mon_clear();
        continue;
      end
      cyc++;
      @(negedge clk);
      if (!rst_n) begin
        mon_clear();
        continue;
      end
      exp_mask = 6'b000000;
      if (prev_mode === 1'b1 && (((cyc - 1) / B) % 2) == 1)
        exp_mask = 6'b000011 << (2 * prev_pos);
      checks++;
      if (bus.o_blink_mask !== exp_mask || bus.o_position === 2'd3) begin
        failures++;
        $display("FAIL blink_mask cyc=%0d got=%b pos=%0d required=%b", cyc, bus.o_blink_mask,
                 bus.o_position, exp_mask);
      end
      if (prev_mode === 1'b0) begin
        tk = (cyc > e_cyc) && (((cyc - e_cyc) % T) == 0);
        checks++;
        if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== {tk, tk & sm_e, tk & sm_e & mm_e}) begin
          failures++;
          $display("FAIL clock_inc cyc=%0d got=%b required=%b", cyc,
                   {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc}, {tk, tk & sm_e, tk & sm_e & mm_e});
        end
      end else begin
        if (bus.o_sec_inc === 1'b1)  setup_inc[0]++;
        if (bus.o_min_inc === 1'b1)  setup_inc[1]++;
        if (bus.o_hour_inc === 1'b1) setup_inc[2]++;
      end
      if (bus.o_mode !== prev_mode) mode_changes++;
      if (prev_mode === 1'b1 && bus.o_mode === 1'b0) e_cyc = cyc;
      prev_mode = bus.o_mode;
      prev_pos  = bus.o_position;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_in) begin
        bus.i_sec_max = 1'($urandom);
        bus.i_min_max = 1'($urandom);
      end
    end
  endtask

  task automatic drive_btn(input logic [2:0] btn, input logic val);
    if (btn[0]) bus.i_sw0 = val;
    if (btn[1]) bus.i_sw1 = val;
    if (btn[2]) bus.i_sw2 = val;
  endtask

  task automatic press(input logic [2:0] btn, input bit bounce, input int hold_strobes);
    @(negedge clk);
    if (bounce) begin
      drive_btn(btn, 1'b0);
      cycles(D);
      drive_btn(btn, 1'b1);
      cycles(D);
    end
    drive_btn(btn, 1'b0);
    cycles(hold_strobes * D);
    drive_btn(btn, 1'b1);
    cycles(8 * D);
  endtask

  task automatic wait_sec(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.o_sec_inc === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_mode, bus.o_position,
         bus.o_blink_mask} !== 12'd0) begin
      failures++;
      $display("FAIL reset_state got=%b required=0", {bus.o_sec_inc, bus.o_min_inc,
               bus.o_hour_inc, bus.o_mode, bus.o_position, bus.o_blink_mask});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tick();
    int hits[$];
    int other = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.o_sec_inc === 1'b1) hits.push_back(cyc);
      if (bus.o_min_inc !== 1'b0 || bus.o_hour_inc !== 1'b0) other++;
    end
    checks++;
    if (hits.size() != 3) begin
      failures++;
      $display("FAIL tick_count got=%0d required=3", hits.size());
    end
    for (int k = 0; k < hits.size() && k < 3; k++) begin
      checks++;
      if (hits[k] != (k + 1) * T) begin
        failures++;
        $display("FAIL tick_cycle idx=%0d got=%0d required=%0d", k, hits[k], (k + 1) * T);
      end
    end
    checks++;
    if (other != 0) begin
      failures++;
      $display("FAIL tick_no_carry got=%0d required=0", other);
    end
  endtask

  task automatic test_carry();
    bit found;
    @(negedge clk);
    bus.i_sec_max = 1'b1;
    bus.i_min_max = 1'b1;
    wait_sec(2 * T, found);
    checks++;
    if (!found || {bus.o_min_inc, bus.o_hour_inc} !== 2'b11) begin
      failures++;
      $display("FAIL carry_full found=%0d got=%b required=11", found, {bus.o_min_inc, bus.o_hour_inc});
    end
    @(negedge clk);
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== 3'b000) begin
      failures++;
      $display("FAIL carry_single_cycle got=%b required=000", {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc});
    end
    bus.i_min_max = 1'b0;
    wait_sec(2 * T, found);
    checks++;
    if (!found || {bus.o_min_inc, bus.o_hour_inc} !== 2'b10) begin
      failures++;
      $display("FAIL carry_min_only found=%0d got=%b required=10", found, {bus.o_min_inc, bus.o_hour_inc});
    end
    bus.i_sec_max = 1'b0;
  endtask

  task automatic test_mode_bounce();
    int mc0 = mode_changes;
    press(3'b001, 1'b1, 20);
    m_mode = 1;
    m_pos  = 0;
    checks++;
    if (mode_changes - mc0 != 1) begin
      failures++;
      $display("FAIL mode_pulse_count got=%0d required=1", mode_changes - mc0);
    end
    checks++;
    if (bus.o_mode !== 1'(m_mode) || bus.o_position !== 2'(m_pos)) begin
      failures++;
      $display("FAIL mode_enter got=%b/%0d required=%0d/%0d", bus.o_mode, bus.o_position, m_mode, m_pos);
    end
  endtask

  task automatic test_position();
    for (int k = 0; k < 3; k++) begin
      press(3'b010, 1'b0, 6);
      m_pos = (m_pos + 1) % 3;
      checks++;
      if (bus.o_position !== 2'(m_pos)) begin
        failures++;
        $display("FAIL position_step k=%0d got=%0d required=%0d", k, bus.o_position, m_pos);
      end
    end
  endtask

  task automatic test_setup_inc();
    int         s0[3];
    int         bad = 0;
    int         chg[$];
    logic [5:0] last;
    press(3'b010, 1'b0, 6);
    m_pos = 1;
    bus.i_sec_max = 1'b1;
    bus.i_min_max = 1'b1;
    s0 = setup_inc;
    press(3'b100, 1'b0, 6);
    checks++;
    if (setup_inc[0] - s0[0] != 0 || setup_inc[1] - s0[1] != 1 || setup_inc[2] - s0[2] != 0) begin
      failures++;
      $display("FAIL setup_inc_min got=%0d/%0d/%0d required=0/1/0", setup_inc[0] - s0[0],
               setup_inc[1] - s0[1], setup_inc[2] - s0[2]);
    end
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
    last = bus.o_blink_mask;
    for (int i = 0; i < 4 * B + 1; i++) begin
      @(negedge clk);
      if (bus.o_blink_mask !== 6'b000000 && bus.o_blink_mask !== 6'b001100) bad++;
      if (bus.o_blink_mask !== last) chg.push_back(cyc);
      last = bus.o_blink_mask;
    end
    checks++;
    if (bad != 0 || chg.size() < 3) begin
      failures++;
      $display("FAIL blink_pattern bad=%0d toggles=%0d required=0/>=3", bad, chg.size());
    end
    for (int k = 1; k < chg.size(); k++) begin
      checks++;
      if (chg[k] - chg[k - 1] != B) begin
        failures++;
        $display("FAIL blink_period got=%0d required=%0d", chg[k] - chg[k - 1], B);
      end
    end
  endtask

  task automatic test_mode_inc_same();
    int s0[3];
    bit found = 1'b0;
    bit found2;
    int e0 = 0;
    s0 = setup_inc;
    @(negedge clk);
    bus.i_sw0 = 1'b0;
    bus.i_sw2 = 1'b0;
    for (int i = 0; i < 48 && !found; i++) begin
      @(negedge clk);
      if (bus.o_mode === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found || {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== 3'b000) begin
      failures++;
      $display("FAIL mode_inc_exit found=%0d got=%b required=000", found,
               {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc});
    end
    e0 = cyc;
    wait_sec(2 * T, found2);
    checks++;
    if (!found2 || cyc - e0 != T) begin
      failures++;
      $display("FAIL first_tick_after_setup found=%0d got=%0d required=%0d", found2, cyc - e0, T);
    end
    bus.i_sw0 = 1'b1;
    bus.i_sw2 = 1'b1;
    cycles(8 * D);
    m_mode = 0;
    checks++;
    if (setup_inc[0] != s0[0] || setup_inc[1] != s0[1] || setup_inc[2] != s0[2] || bus.o_mode !== 1'b0) begin
      failures++;
      $display("FAIL mode_inc_discard got=%0d/%0d/%0d mode=%b required=0/0/0 mode=0",
               setup_inc[0] - s0[0], setup_inc[1] - s0[1], setup_inc[2] - s0[2], bus.o_mode);
    end
  endtask

  task automatic test_random();
    logic [2:0] pat[7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [2:0] btn;
    int         base[3];
    base    = setup_inc;
    m_inc   = '{0, 0, 0};
    rand_in = 1'b1;
    for (int it = 0; it < 16; it++) begin
      btn = pat[$urandom_range(0, 6)];
      press(btn, 1'($urandom), 6);
      if (btn[0]) begin
        if (m_mode == 0) begin
          m_mode = 1;
          m_pos  = 0;
        end else begin
          m_mode = 0;
        end
      end else if (m_mode == 1) begin
        if (btn[1]) m_pos = (m_pos + 1) % 3;
        else if (btn[2]) m_inc[m_pos]++;
      end
      checks++;
      if (bus.o_mode !== 1'(m_mode) || (m_mode == 1 && bus.o_position !== 2'(m_pos))) begin
        failures++;
        $display("FAIL random_state it=%0d btn=%b got=%b/%0d required=%0d/%0d", it, btn,
                 bus.o_mode, bus.o_position, m_mode, m_pos);
      end
    end
    rand_in = 1'b0;
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (setup_inc[k] - base[k] != m_inc[k]) begin
        failures++;
        $display("FAIL random_inc field=%0d got=%0d required=%0d", k, setup_inc[k] - base[k], m_inc[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    if (bus.o_mode !== 1'b1) press(3'b001, 1'b0, 6);
    for (int i = 0; i < 4 * B && !found; i++) begin
      @(negedge clk);
      if (bus.o_blink_mask !== 6'b000000) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_blink_seen got=0 required=1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc, bus.o_mode, bus.o_position,
         bus.o_blink_mask} !== 12'd0) begin
      failures++;
      $display("FAIL reset_async got=%b required=0", {bus.o_sec_inc, bus.o_min_inc,
               bus.o_hour_inc, bus.o_mode, bus.o_position, bus.o_blink_mask});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= T; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc} !== {(i == T), 2'b00}) begin
        failures++;
        $display("FAIL reset_release_tick i=%0d got=%b required=%b", i,
                 {bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc}, {(i == T), 2'b00});
      end
    end
  endtask

  initial begin
    bus.i_sw0     = 1'b1;
    bus.i_sw1     = 1'b1;
    bus.i_sw2     = 1'b1;
    bus.i_sec_max = 1'b0;
    bus.i_min_max = 1'b0;
    fork
      monitor();
      begin
        #300000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "bench timeout");
      end
    join_none
    test_reset();
    test_tick();
    test_carry();
    test_mode_bounce();
    test_position();
    test_setup_inc();
    test_mode_inc_same();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Synchronous mode controller for the HH:MM:SS digital clock. It debounces the three front-panel buttons and runs the CLOCK/SETUP mode state machine. It issues single-cycle increment enables to the seconds, minutes and hours counters and drives a blink mask to the six-digit display multiplexer. Everything runs on the single system clock; no derived clocks leave this block.

## Interface
- TICK_DIV, 50000000: clk cycles per 1 s timebase tick
- DEB_DIV, 500000: clk cycles per debounce sample (100 Hz at 50 MHz)
- BLINK_DIV, 12500000: clk cycles per blink phase toggle (2 Hz blink at 50 MHz)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset; one clock, reset asynchronous and active-low
- i_sw0  in  1  raw MODE button, active-low, asynchronous
- i_sw1  in  1  raw POSITION button, active-low, asynchronous
- i_sw2  in  1  raw INCREMENT button, active-low, asynchronous
- i_sec_max  in  1  seconds counter at terminal value 59, level
- i_min_max  in  1  minutes counter at terminal value 59, level
- o_sec_inc  out  1  one-cycle seconds increment enable
- o_min_inc  out  1  one-cycle minutes increment enable
- o_hour_inc  out  1  one-cycle hours increment enable
- o_mode  out  1  0=CLOCK, 1=SETUP
- o_position  out  2  0=SEC, 1=MIN, 2=HOUR; 3 never produced
- o_blink_mask  out  6  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour

## Operation
- Reset values: o_mode=0, o_position=0, all inc outputs 0, o_blink_mask=0, all counters 0, blink phase 0, debounced states released (1).
- Each button: 2-flop synchronizer into clk, then a 3-sample shift register clocked by a DEB_DIV strobe. Debounced state goes low when 3 consecutive samples are 0, and high when 3 consecutive samples are 1. A press pulse (one clk cycle) fires on the debounced 1->0 transition only; holding a button gives exactly one pulse.
- FSM CLOCK:
  - Tick counter 0..TICK_DIV-1; tick pulse when count==TICK_DIV-1.
  - On tick: o_sec_inc=1; o_min_inc=i_sec_max; o_hour_inc=i_sec_max&i_min_max.
  - POSITION and INCREMENT presses ignored.
  - MODE press -> SETUP, o_position<=SEC.
- FSM SETUP:
  - Tick counter held at 0.
  - POSITION press: SEC->MIN->HOUR->SEC.
  - INCREMENT press: a one-cycle inc on the selected field only, with no carry.
  - MODE press -> CLOCK; the tick counter restarts from 0, so the first tick comes TICK_DIV cycles later.
- Blink: phase toggles every BLINK_DIV cycles, free-running. In SETUP, the selected pair is masked while phase=1 and other bits are 0. In CLOCK the mask is all 0.
- Simultaneous presses in one cycle: MODE wins, and POSITION/INCREMENT are discarded. POSITION and INCREMENT together: position advances first, and the increment is discarded.
- Timer tick coinciding with a MODE press in CLOCK: the tick increment is still issued, then the mode changes.

## Timing
- All outputs are registered; inc outputs are high for exactly one clk.
- Press latency, from raw low to pulse: 2 clk sync + 3 DEB strobes + 1 clk, i.e. between 2*DEB_DIV+3 and 3*DEB_DIV+3 cycles.
- Inc outputs follow the press pulse or the tick by 1 clk. o_mode/o_position update on the same edge as the inc.
- o_blink_mask is valid 1 clk after any change of o_mode, o_position or phase.
- rst_n assertion mid-operation immediately forces all reset values, including any pulse in flight. Deassertion takes effect at the next clk edge.

## Test plan
- Reset, then 3*TICK_DIV cycles in CLOCK with i_sec_max=0 (bench TICK_DIV=10) -> o_sec_inc pulses at cycles 10, 20, 30; o_min_inc and o_hour_inc stay 0.
- CLOCK tick with i_sec_max=1, i_min_max=1 -> o_sec_inc, o_min_inc and o_hour_inc all high in the same single cycle. With i_min_max=0 -> o_hour_inc stays 0.
- Bench DEB_DIV=4:
  - i_sw0 bounce 0/1 for 2 strobes, then held low 20 strobes -> exactly one MODE pulse; o_mode=1, o_position=0.
  - Then 3 i_sw1 presses -> o_position 1, 2, 0.
- SETUP, o_position=1, with i_sec_max=i_min_max=1, press i_sw2 -> one o_min_inc only, no o_sec_inc and no o_hour_inc. o_blink_mask alternates 6'b001100 and 0 every BLINK_DIV cycles.
- i_sw0 and i_sw2 debounced-pressed in the same cycle while in SETUP -> mode returns to CLOCK, no inc pulse. The next o_sec_inc comes exactly TICK_DIV cycles later.
- Assert rst_n mid-SETUP while a blink phase is active -> o_mode=0, o_position=0, o_blink_mask=0 asynchronously, with no inc pulses after release until TICK_DIV cycles have elapsed.
